// File: rtl/sync_pulse_issuer.sv
// Source-side issuer for the two-flop pulse synchronizer: queues event requests as a
// saturating count and releases them one at a time, paced by the synchronizer's ready.
module sync_pulse_issuer #(
    parameter int CNT_W   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN_req,
    output logic             RDY_req,
    input  logic             sync_rdy,
    output logic             sync_en,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_timeout,
    input  logic             clr_err
);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CNT_W-1:0] PEND_FULL = '1;
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP
    } stateT;

    stateT            state;
    logic [TO_W-1:0]  toCnt;
    logic [GAP_W-1:0] gapCnt;
    logic             fire;
    logic             accept;
    logic             drop;
    logic             toHit;

    // The enable is combinational from sync_rdy so a waiting event leaves the same cycle
    // ready is seen; RST_N gating keeps it quiet while the synchronizer is in reset.
    always_comb begin
        RDY_req = (pending != PEND_FULL);
        busy    = (state != S_IDLE) || (pending != '0);
        fire    = RST_N && (state == S_IDLE) && (pending != '0) && sync_rdy;
        sync_en = fire;
        accept  = EN_req && RDY_req;
        drop    = EN_req && !RDY_req;
        toHit   = (state == S_WAIT) && !sync_rdy && (toCnt == TO_LAST);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            pending     <= '0;
            toCnt       <= '0;
            gapCnt      <= '0;
            err_ovf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (accept && !fire) begin
                pending <= pending + CNT_W'(1);
            end else if (fire && !accept) begin
                pending <= pending - CNT_W'(1);
            end

            err_ovf     <= drop || (err_ovf && !clr_err);
            err_timeout <= toHit || (err_timeout && !clr_err);

            // A timed-out pulse is still in flight, so WAIT keeps waiting with the counter pinned.
            unique case (state)
                S_IDLE: begin
                    if (fire) begin
                        state <= S_WAIT;
                        toCnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (sync_rdy) begin
                        toCnt  <= '0;
                        gapCnt <= '0;
                        state  <= (GAP > 0) ? S_GAP : S_IDLE;
                    end else if (toCnt != TO_LIMIT) begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gapCnt <= gapCnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
